// File: rtl/ram_param_clr_pkg.sv
// ============================================================================
//  Module      : ram_param_clr_pkg
//  Description : Shared word size and clear-sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_param_clr_pkg;

    localparam int WORDSIZE = 8;

    localparam logic [0:0] RAMCLR_IDLE  = 1'b0;
    localparam logic [0:0] RAMCLR_CLEAR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_clear_seq.sv
// ============================================================================
//  Module      : ram_clear_seq
//  Description : Walks a pointer over every word, issuing one zero-write per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_clear_seq
    import ram_param_clr_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        if (state_q == RAMCLR_IDLE) begin
            if (clear_req) begin
                state_d = RAMCLR_CLEAR;
                ptr_d   = '0;
            end
        end else begin
            // clear_req is deliberately ignored here: no restart, no extension
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == {ADDR_W{1'b1}}) begin
                state_d = RAMCLR_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= RAMCLR_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == RAMCLR_CLEAR);
    assign clear_done = done_q;
    assign clr_we     = busy;
    assign clr_addr   = ptr_q;

endmodule

`default_nettype wire

// File: rtl/ram_param_clr.sv
// ============================================================================
//  Module      : ram_param_clr
//  Description : 1W/1R register-file RAM with optional registered read and clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_param_clr
    import ram_param_clr_pkg::*;
#(
    parameter int DATA_W   = WORDSIZE,
    parameter int ADDR_W   = 2,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              write_en,
    output logic              wr_accept,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_port_we;
    logic [ADDR_W-1:0] w_port_addr;
    logic [DATA_W-1:0] w_port_data;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .clr_n      (clr_n),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .clr_we     (w_clr_we),
        .clr_addr   (w_clr_addr)
    );

    assign wr_accept = write_en & ~busy & ~clear_req;

    // Single write port: the clear sequencer owns it whenever it is active
    assign w_port_we   = w_clr_we | wr_accept;
    assign w_port_addr = w_clr_we ? w_clr_addr : wr_addr;
    assign w_port_data = w_clr_we ? '0 : data_in;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (w_port_we && (w_port_addr == ADDR_W'(i))) begin
                mem_d[i] = w_port_data;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd_data_q, rd_data_d;
            logic              rd_valid_q, rd_valid_d;

            // Reading the next-state array gives write-first bypass for free
            always_comb begin
                rd_data_d  = rd_en ? mem_d[rd_addr] : rd_data_q;
                rd_valid_d = rd_en;
            end

            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_rd_comb
            logic unused_rd_en;

            assign unused_rd_en = rd_en;
            assign rd_data      = mem_q[rd_addr];
            assign rd_valid     = 1'b1;
        end
    endgenerate

endmodule

`default_nettype wire
